// File: rtl/axis_stream_scoreboard_if.sv
// Scoreboard bus: expected-beat push channel and observed AXI4-Stream.
// master = stimulus/DUT side; slave = scoreboard side.
interface axis_stream_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              exp_last;

  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic [DATA_W/8-1:0] s_axis_tkeep;
  logic                s_axis_tlast;

  modport master (
    output exp_valid, exp_data, exp_last,
    output s_axis_tvalid, s_axis_tdata,
    output s_axis_tkeep, s_axis_tlast,
    input  exp_ready, s_axis_tready
  );

  modport slave (
    input  exp_valid, exp_data, exp_last,
    input  s_axis_tvalid, s_axis_tdata,
    input  s_axis_tkeep, s_axis_tlast,
    output exp_ready, s_axis_tready
  );
endinterface

// File: rtl/axis_stream_scoreboard.sv
// In-order AXI4-Stream scoreboard: FIFO of expected beats vs observed.
// Ports: ACLK/ARESET, bus (slave), start/flush/cfg_beats, status, counters,
// first_err_*. Define KEEP_MASK_EN to compare only tkeep-enabled bytes.
module axis_stream_scoreboard #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axis_stream_scoreboard_if.slave bus,
  input  logic                  start,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      cfg_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  halted,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic [CNT_W-1:0]      first_err_idx,
  output logic [DATA_W-1:0]     first_err_exp,
  output logic [DATA_W-1:0]     first_err_act
);
  localparam int AW = $clog2(DEPTH);
  localparam bit StopOnErr = (STOP_ON_ERR != 0);

  typedef enum logic [1:0] {
    IDLE, RUN, DONE, HALT
  } state_t;

  state_t state, stateNext;

  logic [DATA_W:0] mem [DEPTH];
  logic [AW:0]     wrPtr, rdPtr;
  logic            fifoEmpty, fifoFull;
  logic            push, doFlush, tready;
  logic [DATA_W-1:0] expData;
  logic            expLast;

  logic            hs, dataDiff, mismatch, startAcc;
  logic [CNT_W-1:0] cfgBeats, beatNext;
  logic [CNT_W-1:0] passNext, failNext;

  // Extra pointer MSB distinguishes full from empty.
  assign fifoEmpty = wrPtr == rdPtr;
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) &&
                     (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  assign bus.exp_ready     = !fifoFull;
  assign tready            = (state == RUN) && !fifoEmpty;
  assign bus.s_axis_tready = tready;

  assign push    = bus.exp_valid && !fifoFull;
  assign doFlush = flush && (state != RUN);
  assign hs      = bus.s_axis_tvalid && tready;

  assign {expLast, expData} = mem[rdPtr[AW-1:0]];

  always_ff @(posedge ACLK) begin
    if (push && !doFlush && !ARESET)
      mem[wrPtr[AW-1:0]] <= {bus.exp_last, bus.exp_data};
  end

  // Flush drops both the contents and any same-cycle push.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (doFlush) begin
      rdPtr <= wrPtr;
    end else begin
      if (push) wrPtr <= wrPtr + (AW+1)'(1);
      if (hs)   rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

`ifdef KEEP_MASK_EN
  logic [DATA_W-1:0] keepMask;
  always_comb begin
    keepMask = '0;
    for (int i = 0; i < DATA_W/8; i++)
      keepMask[i*8 +: 8] = {8{bus.s_axis_tkeep[i]}};
  end
  assign dataDiff = |((bus.s_axis_tdata ^ expData) & keepMask);
`else
  logic unusedKeep;
  assign unusedKeep = ^bus.s_axis_tkeep;
  assign dataDiff   = bus.s_axis_tdata != expData;
`endif

  assign mismatch = dataDiff || (bus.s_axis_tlast != expLast);
  assign startAcc = start && (state != RUN);

  assign beatNext = (&beat_cnt) ? beat_cnt : beat_cnt + CNT_W'(1);
  assign passNext = (&pass_cnt) ? pass_cnt : pass_cnt + CNT_W'(1);
  assign failNext = (&fail_cnt) ? fail_cnt : fail_cnt + CNT_W'(1);

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= stateNext;
  end

  // A mismatching final beat halts rather than completes.
  always_comb begin
    stateNext = state;
    unique case (state)
      RUN: begin
        if (hs) begin
          if (mismatch && StopOnErr)
            stateNext = HALT;
          else if (beatNext == cfgBeats)
            stateNext = DONE;
        end
      end
      IDLE, DONE, HALT: begin
        if (start)
          stateNext = (cfg_beats == '0) ? DONE : RUN;
      end
      default: stateNext = IDLE;
    endcase
  end

  // fail_cnt == 0 marks the first mismatch; it saturates, never wraps.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cfgBeats      <= '0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      beat_cnt      <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else if (startAcc) begin
      cfgBeats      <= cfg_beats;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      beat_cnt      <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else if (hs) begin
      beat_cnt <= beatNext;
      if (mismatch) begin
        fail_cnt <= failNext;
        if (fail_cnt == '0) begin
          first_err_idx <= beat_cnt;
          first_err_exp <= expData;
          first_err_act <= bus.s_axis_tdata;
        end
      end else begin
        pass_cnt <= passNext;
      end
    end
  end

  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign halted = state == HALT;
endmodule
